// File: rtl/arm_rx_pkg.sv
// Shared types and constants for the ARM receive-side blocks.
package arm_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  localparam logic [7:0]  DEST_RETURN3      = 8'h01;
  localparam logic [7:0]  DEST_PINGPANG     = 8'h02;
  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;

endpackage

// File: rtl/arm_rx_timeout.sv
// Idle-cycle watchdog: counts enabled cycles without a clear and flags the
// TIMEOUT_CYC-th one. A clear in the expiry cycle suppresses the expiry.
module arm_rx_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != LP_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && !i_clear && (r_cnt == LP_LAST);

endmodule

// File: rtl/arm_rx_dispatch.sv
// Parses framed ARM words and routes payload to return3 or pingpang RAM.
// Optional trailing checksum word is enabled by ARM_RX_CHECKSUM_EN.
module arm_rx_dispatch
  import arm_rx_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          MAX_LEN     = 512,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       data_from_arm,
  input  logic              arm_to_fpga,
  output logic [15:0]       return3_cfg_data,
  output logic              return3_cfg_flag,
  output logic [15:0]       pingpang_wr_data,
  output logic [ADDR_W-1:0] pingpang_wr_addr,
  output logic              pingpang_wr_en,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int          CNT_W      = $clog2(MAX_LEN + 1);
  localparam logic [15:0] LP_MAX_LEN = 16'(MAX_LEN);

  state_t              r_state, w_state_nxt;
  logic                r_dest_pp, w_dest_pp_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                w_r3_flag, w_pp_en, w_done, w_err;
  logic                w_busy, w_expire;
`ifdef ARM_RX_CHECKSUM_EN
  logic [15:0]         r_sum, w_sum_nxt;
`endif

  assign w_busy = (r_state != ST_IDLE);
  assign busy   = w_busy;

  arm_rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (w_busy),
    .i_clear  (arm_to_fpga),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_dest_pp <= 1'b0;
      r_cnt     <= '0;
      r_addr    <= '0;
`ifdef ARM_RX_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_dest_pp <= w_dest_pp_nxt;
      r_cnt     <= w_cnt_nxt;
      r_addr    <= w_addr_nxt;
`ifdef ARM_RX_CHECKSUM_EN
      r_sum     <= w_sum_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dest_pp_nxt = r_dest_pp;
    w_cnt_nxt     = r_cnt;
    w_addr_nxt    = r_addr;
    w_r3_flag     = 1'b0;
    w_pp_en       = 1'b0;
    w_done        = 1'b0;
    w_err         = 1'b0;
`ifdef ARM_RX_CHECKSUM_EN
    w_sum_nxt     = r_sum;
`endif
    case (r_state)
      ST_IDLE: begin
        if (arm_to_fpga && data_from_arm == SYNC_WORD) w_state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (arm_to_fpga) begin
          if (data_from_arm[15:8] == DEST_RETURN3 || data_from_arm[15:8] == DEST_PINGPANG) begin
            w_dest_pp_nxt = (data_from_arm[15:8] == DEST_PINGPANG);
            w_state_nxt   = ST_LEN;
`ifdef ARM_RX_CHECKSUM_EN
            w_sum_nxt     = data_from_arm;
`endif
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_LEN: begin
        if (arm_to_fpga) begin
          if (data_from_arm == 16'd0 || data_from_arm > LP_MAX_LEN) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt   = data_from_arm[CNT_W-1:0];
            w_addr_nxt  = '0;
            w_state_nxt = ST_PAYLOAD;
`ifdef ARM_RX_CHECKSUM_EN
            w_sum_nxt   = r_sum + data_from_arm;
`endif
          end
        end
      end
      ST_PAYLOAD: begin
        if (arm_to_fpga) begin
          w_r3_flag = !r_dest_pp;
          w_pp_en   = r_dest_pp;
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_dest_pp) w_addr_nxt = r_addr + 1'b1;
`ifdef ARM_RX_CHECKSUM_EN
          w_sum_nxt = r_sum + data_from_arm;
          if (r_cnt == CNT_W'(1)) w_state_nxt = ST_CSUM;
`else
          if (r_cnt == CNT_W'(1)) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
`endif
        end
      end
`ifdef ARM_RX_CHECKSUM_EN
      ST_CSUM: begin
        if (arm_to_fpga) begin
          w_done      = (data_from_arm == r_sum);
          w_err       = (data_from_arm != r_sum);
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
    // Expiry only fires in strobe-free cycles, so it never collides with a word.
    if (w_expire) begin
      w_state_nxt = ST_IDLE;
      w_err       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      return3_cfg_data <= '0;
      return3_cfg_flag <= 1'b0;
      pingpang_wr_data <= '0;
      pingpang_wr_addr <= '0;
      pingpang_wr_en   <= 1'b0;
      frame_done       <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      return3_cfg_flag <= w_r3_flag;
      pingpang_wr_en   <= w_pp_en;
      frame_done       <= w_done;
      frame_err        <= w_err;
      if (w_r3_flag) return3_cfg_data <= data_from_arm;
      if (w_pp_en) begin
        pingpang_wr_data <= data_from_arm;
        pingpang_wr_addr <= r_addr;
      end
    end
  end

endmodule

// File: tb/tb_arm_rx_dispatch.sv
// Directed bench for arm_rx_dispatch with an expected-event scoreboard.
// Build with ARM_RX_CHECKSUM_EN defined to exercise the checksum path.
module tb_arm_rx_dispatch;

  localparam int AW    = 10;
  localparam int MAXL  = 1100;
  localparam int TO    = 64;
  localparam int EW    = 28;
  localparam logic [1:0] K_R3 = 2'd0, K_PP = 2'd1, K_DONE = 2'd2, K_ERR = 2'd3;
  localparam logic [15:0] SYNC = 16'hA55A;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   data_from_arm = '0;
  logic          arm_to_fpga = 1'b0;
  logic [15:0]   return3_cfg_data;
  logic          return3_cfg_flag;
  logic [15:0]   pingpang_wr_data;
  logic [AW-1:0] pingpang_wr_addr;
  logic          pingpang_wr_en;
  logic          frame_done;
  logic          frame_err;
  logic          busy;

  logic [EW-1:0] exp_q[$];
  int            stamp_q[$];
  int            cyc = 0;
  int            last_cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  arm_rx_dispatch #(.ADDR_W(AW), .MAX_LEN(MAXL), .TIMEOUT_CYC(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_from_arm    (data_from_arm),
    .arm_to_fpga      (arm_to_fpga),
    .return3_cfg_data (return3_cfg_data),
    .return3_cfg_flag (return3_cfg_flag),
    .pingpang_wr_data (pingpang_wr_data),
    .pingpang_wr_addr (pingpang_wr_addr),
    .pingpang_wr_en   (pingpang_wr_en),
    .frame_done       (frame_done),
    .frame_err        (frame_err),
    .busy             (busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [15:0] w);
    @(negedge clk);
    data_from_arm = w;
    arm_to_fpga   = 1'b1;
    last_cyc      = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      arm_to_fpga = 1'b0;
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [AW-1:0] a, input logic [15:0] d, input int st);
    exp_q.push_back({k, a, d});
    stamp_q.push_back(st);
  endtask

  task automatic send_frame(input logic [15:0] hdr, input int len, input logic [15:0] base);
    logic [15:0] w;
    logic [31:0] iv;
`ifdef ARM_RX_CHECKSUM_EN
    logic [15:0] sum;
    sum = hdr + 16'(len);
`endif
    send(SYNC);
    send(hdr);
    send(16'(len));
    for (int i = 0; i < len; i++) begin
      w  = base + 16'(i);
      iv = 32'(i);
      send(w);
`ifdef ARM_RX_CHECKSUM_EN
      sum = sum + w;
`endif
      if (hdr[15:8] == 8'h01) push(K_R3, '0, w, last_cyc + 1);
      else                    push(K_PP, iv[AW-1:0], w, last_cyc + 1);
    end
`ifdef ARM_RX_CHECKSUM_EN
    send(sum);
`endif
    push(K_DONE, '0, '0, last_cyc + 1);
    idle(2);
  endtask

  // scoreboard monitor
  task automatic check_evt(input logic [1:0] k, input logic [AW-1:0] a, input logic [15:0] d);
    logic [EW-1:0] e;
    int st;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %0d data %h at cyc %0d, expected none", k, a, d, cyc);
    end else begin
      e  = exp_q.pop_front();
      st = stamp_q.pop_front();
      if (e !== {k, a, d} || st != cyc) begin
        n_fail++;
        $display("FAIL event: got kind %0d addr %0d data %h cyc %0d, expected kind %0d addr %0d data %h cyc %0d",
                 k, a, d, cyc, e[EW-1:EW-2], e[EW-3:16], e[15:0], st);
      end
    end
  endtask

  always @(negedge clk) begin
    if (return3_cfg_flag === 1'b1) check_evt(K_R3, '0, return3_cfg_data);
    if (pingpang_wr_en === 1'b1)   check_evt(K_PP, pingpang_wr_addr, pingpang_wr_data);
    if (frame_done === 1'b1)       check_evt(K_DONE, '0, '0);
    if (frame_err === 1'b1)        check_evt(K_ERR, '0, '0);
    if (frame_done === 1'b1 || frame_err === 1'b1) begin
      n_checks++;
      if (frame_done === 1'b1 && frame_err === 1'b1) begin
        n_fail++;
        $display("FAIL done_err_excl: got both 1, expected at most one");
      end
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_outs"}, {return3_cfg_data, return3_cfg_flag, pingpang_wr_data, pingpang_wr_en,
                         frame_done, frame_err, busy}, '0);
    chk({tag, "_addr"}, 32'(pingpang_wr_addr), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    idle(2);

    // return3 frame
    send_frame(16'h0100, 3, 16'h1111);
    idle(1);
    // the 3 words are 1111/1112/1113; also the exact test-plan words
    send(SYNC); send(16'h0100); send(16'h0003);
    send(16'h1111); push(K_R3, '0, 16'h1111, last_cyc + 1);
    send(16'h2222); push(K_R3, '0, 16'h2222, last_cyc + 1);
    send(16'h3333); push(K_R3, '0, 16'h3333, last_cyc + 1);
`ifdef ARM_RX_CHECKSUM_EN
    send(16'h0100 + 16'h0003 + 16'h1111 + 16'h2222 + 16'h3333);
`endif
    push(K_DONE, '0, '0, last_cyc + 1);
    idle(2);
    chk("busy_after_r3", 32'(busy), 32'd0);

    // pingpang frames, address restarts per frame, then wrap
    send_frame(16'h02FF, 4, 16'hA000);
    send_frame(16'h0200, 4, 16'hB000);
    send_frame(16'h0200, 1030, 16'hC000);

    // junk in IDLE
    send(16'h1234); send(16'h5678); idle(2);
    chk("busy_junk", 32'(busy), 32'd0);

    // bad dest
    send(SYNC); send(16'h0300); push(K_ERR, '0, '0, last_cyc + 1); idle(2);
    chk("busy_bad_dest", 32'(busy), 32'd0);

    // bad lengths
    send(SYNC); send(16'h0200); send(16'd0); push(K_ERR, '0, '0, last_cyc + 1); idle(2);
    send(SYNC); send(16'h0100); send(16'(MAXL + 1)); push(K_ERR, '0, '0, last_cyc + 1); idle(2);
    chk("busy_bad_len", 32'(busy), 32'd0);

    // timeout mid-payload after exactly TO idle cycles
    send(SYNC); send(16'h0200); send(16'd5);
    send(16'hD000); push(K_PP, 10'd0, 16'hD000, last_cyc + 1);
    send(16'hD001); push(K_PP, 10'd1, 16'hD001, last_cyc + 1);
    push(K_ERR, '0, '0, last_cyc + 1 + TO);
    idle(TO - 1);
    chk("busy_before_expiry", 32'(busy), 32'd1);
    idle(3);
    chk("busy_timeout", 32'(busy), 32'd0);

    // strobe lands exactly on the expiry cycle: accepted
    send(SYNC); send(16'h0100); send(16'd2);
    send(16'hE000); push(K_R3, '0, 16'hE000, last_cyc + 1);
    idle(TO - 1);
    send(16'hE001); push(K_R3, '0, 16'hE001, last_cyc + 1);
`ifdef ARM_RX_CHECKSUM_EN
    idle(1);
    send(16'h0100 + 16'd2 + 16'hE000 + 16'hE001);
`endif
    push(K_DONE, '0, '0, last_cyc + 1);
    idle(3);

`ifdef ARM_RX_CHECKSUM_EN
    // wrong checksum: payload still forwarded, then error only
    send(SYNC); send(16'h0200); send(16'd2);
    send(16'h0010); push(K_PP, 10'd0, 16'h0010, last_cyc + 1);
    send(16'h0020); push(K_PP, 10'd1, 16'h0020, last_cyc + 1);
    send(16'hBEEF); push(K_ERR, '0, '0, last_cyc + 1);
    idle(3);
`endif

    // reset mid-payload: silent drop, then a normal frame
    send(SYNC); send(16'h0200); send(16'd4);
    send(16'hF000); push(K_PP, 10'd0, 16'hF000, last_cyc + 1);
    send(16'hF001); push(K_PP, 10'd1, 16'hF001, last_cyc + 1);
    @(negedge clk);
    arm_to_fpga = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_outputs_zero("mid_reset");
    idle(3);
    send_frame(16'h0200, 3, 16'h5000);

    idle(5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
